// File: rtl/xadc_drp_responder.sv
// DRP slave emulating the XADC register file: status registers are fed from a
// sample stream, config registers are read/write over DRP with fixed latency.
module xadc_drp_responder #(
  parameter int          READ_LATENCY = 4,
  parameter logic [15:0] CFG_RESET    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  daddr,
  input  logic        den,
  input  logic        dwe,
  input  logic [15:0] di,
  output logic [15:0] dout,
  output logic        drdy,
  output logic        busy,
  input  logic        sample_valid,
  input  logic [4:0]  sample_ch,
  input  logic [15:0] sample_data,
  output logic        eoc,
  output logic [4:0]  channel,
  output logic        proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT   = 4'(READ_LATENCY - 1);
  localparam bit         SKIP_WAIT  = (READ_LATENCY <= 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic        accept;
  logic        is_write;
  logic [15:0] rdata;
  logic [15:0] rd_value;
  logic [15:0] status_q [32];
  logic [15:0] cfg_q    [64];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // cnt holds the number of WAIT cycles still to run, including the current one
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    busy       = 1'b0;
    drdy       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (den) begin
          accept     = 1'b1;
          cnt_next   = CNT_INIT;
          state_next = SKIP_WAIT ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy = 1'b1;
        if (cnt <= 4'd1) begin
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      ST_RESP: begin
        busy       = 1'b1;
        drdy       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    rd_value = 16'h0000;
    if (daddr[6]) begin
      rd_value = cfg_q[daddr[5:0]];
    end else if (!daddr[5]) begin
      rd_value = status_q[daddr[4:0]];
    end
  end

  assign dout = (drdy && !is_write) ? rdata : 16'h0000;

  // rdata is captured from the pre-edge register contents, so a sample landing
  // on the same edge is not visible to this read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata     <= 16'h0000;
      is_write  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        rdata    <= dwe ? 16'h0000 : rd_value;
        is_write <= dwe;
      end
      if (den && (state != ST_IDLE)) begin
        proto_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eoc     <= 1'b0;
      channel <= 5'd0;
    end else begin
      eoc <= sample_valid;
      if (sample_valid) begin
        channel <= sample_ch;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        status_q[i] <= 16'h0000;
      end
    end else if (sample_valid) begin
      status_q[sample_ch] <= sample_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) begin
        cfg_q[i] <= CFG_RESET;
      end
    end else if (accept && dwe && daddr[6]) begin
      cfg_q[daddr[5:0]] <= di;
    end
  end

endmodule

// File: tb/tb_xadc_drp_responder.sv
// Bench for xadc_drp_responder: directed scenarios plus a randomized scan,
// all checked cycle by cycle against a transaction-level register model.
module tb_xadc_drp_responder;

  localparam int          L      = 4;
  localparam logic [15:0] CFG_RV = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  daddr;
  logic        den;
  logic        dwe;
  logic [15:0] di;
  logic [15:0] dout;
  logic        drdy;
  logic        busy;
  logic        sample_valid;
  logic [4:0]  sample_ch;
  logic [15:0] sample_data;
  logic        eoc;
  logic [4:0]  channel;
  logic        proto_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_status [32];
  logic [15:0] m_cfg    [64];
  logic [15:0] m_rdata;
  int          remaining;
  logic        m_perr;
  logic        m_eoc;
  logic [4:0]  m_ch;

  logic [6:0] scan_addr [4] = '{7'h13, 7'h1A, 7'h12, 7'h1B};

  xadc_drp_responder #(.READ_LATENCY(L), .CFG_RESET(CFG_RV)) dut (
    .clk(clk), .reset(reset), .daddr(daddr), .den(den), .dwe(dwe), .di(di),
    .dout(dout), .drdy(drdy), .busy(busy), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .sample_data(sample_data), .eoc(eoc),
    .channel(channel), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] model_read(input logic [6:0] a);
    if (a >= 7'h40) return m_cfg[a - 7'h40];
    if (a < 7'h20) return m_status[a[4:0]];
    return 16'h0000;
  endfunction

  task automatic reset_model();
    for (int i = 0; i < 32; i++) m_status[i] = 16'h0000;
    for (int i = 0; i < 64; i++) m_cfg[i] = CFG_RV;
    m_rdata = 16'h0000;
    remaining = 0;
    m_perr = 1'b0;
    m_eoc = 1'b0;
    m_ch = 5'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("drdy", {31'd0, drdy}, {31'd0, remaining == 1});
    check("busy", {31'd0, busy}, {31'd0, remaining != 0});
    check("dout", {16'd0, dout}, {16'd0, (remaining == 1) ? m_rdata : 16'h0000});
    check("eoc", {31'd0, eoc}, {31'd0, m_eoc});
    check("channel", {27'd0, channel}, {27'd0, m_ch});
    check("proto_err", {31'd0, proto_err}, {31'd0, m_perr});
  endtask

  // One clock: update the model from the inputs seen at this edge, then check
  task automatic apply_stimulus();
    logic was_busy;
    @(posedge clk);
    if (reset) begin
      was_busy = (remaining != 0);
      if (remaining != 0) remaining--;
      if (den) begin
        if (was_busy) begin
          m_perr = 1'b1;
        end else begin
          remaining = L;
          m_rdata = dwe ? 16'h0000 : model_read(daddr);
          if (dwe && daddr >= 7'h40) m_cfg[daddr - 7'h40] = di;
        end
      end
      m_eoc = sample_valid;
      if (sample_valid) begin
        m_status[sample_ch] = sample_data;
        m_ch = sample_ch;
      end
    end
    #1;
    den = 1'b0;
    sample_valid = 1'b0;
    check_output();
  endtask

  task automatic txn(input logic [6:0] a, input logic we, input logic [15:0] d,
                     input logic [15:0] exp, input string tag);
    den = 1'b1; daddr = a; dwe = we; di = d;
    apply_stimulus();
    for (int k = 1; k < L; k++) apply_stimulus();
    check({tag, "_drdy"}, {31'd0, drdy}, 32'd1);
    check({tag, "_dout"}, {16'd0, dout}, {16'd0, exp});
    apply_stimulus();
  endtask

  task automatic random_sample();
    if ($urandom_range(0, 1) == 1) begin
      sample_valid = 1'b1;
      sample_ch = scan_addr[$urandom_range(0, 3)][4:0];
      sample_data = {12'($urandom), 4'h0};
    end
  endtask

  initial begin
    logic [6:0]  a;
    logic [15:0] exp;
    reset = 1'b0; den = 1'b0; dwe = 1'b0; daddr = 7'd0; di = 16'd0;
    sample_valid = 1'b0; sample_ch = 5'd0; sample_data = 16'd0;
    reset_model();
    for (int i = 0; i < 5; i++) apply_stimulus();
    reset = 1'b1;
    apply_stimulus();
    txn(7'h41, 1'b0, 16'h0, 16'h0000, "rst_rd41");

    sample_valid = 1'b1; sample_ch = 5'h13; sample_data = 16'hABC0;
    apply_stimulus();
    txn(7'h13, 1'b0, 16'h0, 16'hABC0, "samp_rd13");

    txn(7'h41, 1'b1, 16'h2FF0, 16'h0000, "wr41");
    txn(7'h41, 1'b0, 16'h0, 16'h2FF0, "rd41");
    txn(7'h05, 1'b1, 16'h1234, 16'h0000, "wr05");
    txn(7'h05, 1'b0, 16'h0, 16'h0000, "rd05");
    txn(7'h25, 1'b1, 16'hBEEF, 16'h0000, "wr25");
    txn(7'h25, 1'b0, 16'h0, 16'h0000, "rd25");

    den = 1'b1; daddr = 7'h41; dwe = 1'b0;
    apply_stimulus();
    apply_stimulus();
    den = 1'b1; daddr = 7'h05; dwe = 1'b1; di = 16'h7777;
    apply_stimulus();
    check("perr_t3", {31'd0, proto_err}, 32'd1);
    apply_stimulus();
    check("perr_drdy", {31'd0, drdy}, 32'd1);
    check("perr_dout", {16'd0, dout}, {16'd0, 16'h2FF0});
    apply_stimulus();
    txn(7'h13, 1'b0, 16'h0, 16'hABC0, "after_perr");
    check("perr_sticky", {31'd0, proto_err}, 32'd1);

    sample_valid = 1'b1; sample_ch = 5'h1A; sample_data = 16'h1110;
    apply_stimulus();
    sample_valid = 1'b1; sample_ch = 5'h1A; sample_data = 16'h5550;
    den = 1'b1; daddr = 7'h1A; dwe = 1'b0;
    apply_stimulus();
    check("coll_eoc", {31'd0, eoc}, 32'd1);
    check("coll_ch", {27'd0, channel}, {27'd0, 5'h1A});
    for (int k = 1; k < L; k++) apply_stimulus();
    check("coll_dout", {16'd0, dout}, {16'd0, 16'h1110});
    apply_stimulus();
    txn(7'h1A, 1'b0, 16'h0, 16'h5550, "coll_reread");

    reset = 1'b0;
    reset_model();
    apply_stimulus();
    reset = 1'b1;
    apply_stimulus();
    for (int n = 0; n < 1000; n++) begin
      a = scan_addr[n % 4];
      exp = model_read(a);
      den = 1'b1; daddr = a; dwe = 1'b0;
      random_sample();
      apply_stimulus();
      for (int k = 1; k < L; k++) begin
        random_sample();
        apply_stimulus();
      end
      check("scan_dout", {16'd0, dout}, {16'd0, exp});
      random_sample();
      apply_stimulus();
    end
    check("scan_perr", {31'd0, proto_err}, 32'd0);

    den = 1'b1; daddr = 7'h13; dwe = 1'b0;
    apply_stimulus();
    apply_stimulus();
    reset = 1'b0;
    #1;
    reset_model();
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_drdy", {31'd0, drdy}, 32'd0);
    for (int i = 0; i < 2; i++) apply_stimulus();
    reset = 1'b1;
    for (int i = 0; i < L + 2; i++) apply_stimulus();
    txn(7'h13, 1'b0, 16'h0, 16'h0000, "post_rst_rd13");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
